mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one 16-bit memory port between the instruction-fetch path (requester 0) and the load/store path (requester 1) of the CompactRISC16 core. It drives the select line of the 2:1 port multiplexers and returns a one-hot grant to each requester. Arbitration is round-robin with a registered grant, and an optional hold-limit timeout prevents starvation.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles while the other requester waits. Legal range 2..15. Used only with ARB_TIMEOUT_EN.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

- I_CLK  input  1  clock; all state changes on the rising edge.
- I_RESET  input  1  asynchronous, active-high reset.
- I_REQ  input  2  request per requester; held high for the whole transaction.
- O_GNT  output  2  registered one-hot grant; never both bits set.
- O_SEL  output  1  mux select; index of the current or most recent grantee.
- O_BUSY  output  1  high whenever either O_GNT bit is high.
- O_PREEMPT  output  1  one-cycle pulse when a grant is forcibly revoked by timeout.

## Operation
- FSM states: IDLE, GNT0, GNT1. O_GNT is decoded from the state register: IDLE=00, GNT0=01, GNT1=10.
- Priority pointer `last` records the index of the most recent grantee. The requester not equal to `last` wins ties.
- IDLE transitions:
  - Only I_REQ[k] high: go to GNTk.
  - Both high: go to GNT(!last).
  - None high: stay in IDLE.
- GNTk transitions:
  - I_REQ[k] low and I_REQ[!k] high: go directly to GNT(!k). No idle bubble.
  - I_REQ[k] low and I_REQ[!k] low: go to IDLE.
  - I_REQ[k] high: stay in GNTk, subject to the timeout rule.
- On every entry to GNTk: `last`←k, O_SEL←k. Both hold their values in IDLE.
- Hold counter:
  - Clears on entry to any GNT state.
  - Increments each cycle the grant holds while the other requester is asserted.
  - Saturates at MAX_HOLD.
  - Clears whenever the other requester is low.
- Reset values: state IDLE, O_GNT=00, O_SEL=0, O_BUSY=0, O_PREEMPT=0, `last`=1 (so requester 0 wins the first tie), counter=0.
- Reset asserted mid-grant: the grant drops immediately, asynchronously. On release, the block resumes from IDLE with the reset priority.

## Timing
- Grant latency: I_REQ rising at edge n (sampled) gives O_GNT high after edge n, i.e. one cycle.
- Release latency: I_REQ[k] sampled low at edge n gives O_GNT[k] low after edge n. O_GNT[!k] rises in the same cycle if requester !k is waiting.
- O_SEL changes only on the same edge that a new grant bit rises, so the mux switches together with the grant.
- A requester may drop its request only while granted or idle. Dropping while ungranted withdraws the request with no side effects.
- Requester k reasserting in the cycle after its own release, while !k is waiting, loses to !k because of round-robin.
- O_PREEMPT is registered and high for exactly the cycle in which the new grant first appears.

## Configuration
- ARB_TIMEOUT_EN defined:
  - In GNTk with I_REQ[k] and I_REQ[!k] both high and counter==MAX_HOLD-1, the next edge moves to GNT(!k) and pulses O_PREEMPT.
  - Requester k must tolerate losing its grant mid-transaction and re-arbitrate.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and O_PREEMPT is tied to 0.
  - The grant holder keeps the port as long as its request stays high.

## Test plan
- Reset then single request: I_REQ=01 → O_GNT=01, O_SEL=0, O_BUSY=1 one cycle later. Then I_REQ=00 → O_GNT=00 one cycle later, with O_SEL still 0.
- Simultaneous requests from reset: I_REQ=11 → O_GNT=01. Drop bit 0 → O_GNT=10, O_SEL=1 on the next edge with no idle cycle. Drop bit 1 → IDLE. Reassert I_REQ=11 → O_GNT=01 (last=1).
- Back-to-back alternation: requester 1 held, requester 0 pulsing a 3-cycle request every 4 cycles → grants alternate and never overlap. O_GNT is one-hot or zero on every cycle.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): I_REQ=11 held → O_GNT=01 for exactly 8 cycles, then 10 with a one-cycle O_PREEMPT pulse, then 01 again after 8 more cycles.
- No timeout (macro undefined): I_REQ=11 held for 50 cycles → O_GNT stays 01 and O_PREEMPT stays 0.
- Asynchronous reset during GNT1: assert I_RESET mid-cycle → O_GNT=00, O_BUSY=0 before the next edge. After release with I_REQ=11 → O_GNT=01.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbitration bundle between the two requesters and the arbiter.
// master: requester side (drives I_REQ); slave: arbiter side (drives grants).
interface mem_port_arbiter_if;
  logic [1:0] I_REQ;
  logic [1:0] O_GNT;
  logic       O_SEL;
  logic       O_BUSY;
  logic       O_PREEMPT;

  modport master (
    output I_REQ,
    input  O_GNT,
    input  O_SEL,
    input  O_BUSY,
    input  O_PREEMPT
  );

  modport slave (
    input  I_REQ,
    output O_GNT,
    output O_SEL,
    output O_BUSY,
    output O_PREEMPT
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory port between instruction
// fetch (requester 0) and load/store (requester 1). Grant is registered and
// decoded from the state register.
// Optional feature: define ARB_TIMEOUT_EN to build the hold-limit counter that
// revokes a grant after MAX_HOLD cycles while the other requester waits.
//
// state | meaning
// IDLE  | no grant, port select holds last grantee
// GNT0  | requester 0 owns the port
// GNT1  | requester 1 owns the port
module mem_port_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Reject parameter sets the hold counter cannot represent.
  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << CNT_W) <= MAX_HOLD) begin : g_param_check
    $error("mem_port_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   r_sel;
  logic   w_entry;
  logic   w_new_idx;
  logic   w_timeout;

  assign w_entry   = (w_next != IDLE) && (w_next != r_state);
  assign w_new_idx = (w_next == GNT1);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_preempt;
  logic             w_other;

  // The waiting requester is the one opposite the current grantee.
  assign w_other   = (r_state == GNT0) ? bus.I_REQ[1] : bus.I_REQ[0];
  // Holder still wants the port but the other side has waited long enough.
  assign w_timeout = (r_state != IDLE) && (bus.I_REQ == 2'b11) &&
                     (r_cnt == CNT_W'(MAX_HOLD - 1));

  // Hold counter: restarts on each new grant, counts only while the other side waits.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_cnt <= '0;
    end else if (w_entry) begin
      r_cnt <= '0;
    end else if (r_state != IDLE && w_other) begin
      if (r_cnt != CNT_W'(MAX_HOLD)) r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Preempt pulse lines up with the first cycle of the replacement grant.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) r_preempt <= 1'b0;
    else         r_preempt <= w_timeout;
  end

  assign bus.O_PREEMPT = r_preempt;
`else
  assign w_timeout     = 1'b0;
  assign bus.O_PREEMPT = 1'b0;
`endif

  // Next-state logic: round-robin on ties, direct hand-over without an idle bubble.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        case (bus.I_REQ)
          2'b01:   w_next = GNT0;
          2'b10:   w_next = GNT1;
          2'b11:   w_next = r_last ? GNT0 : GNT1;
          default: w_next = IDLE;
        endcase
      end
      GNT0: begin
        if (!bus.I_REQ[0])  w_next = bus.I_REQ[1] ? GNT1 : IDLE;
        else if (w_timeout) w_next = GNT1;
      end
      GNT1: begin
        if (!bus.I_REQ[1])  w_next = bus.I_REQ[0] ? GNT0 : IDLE;
        else if (w_timeout) w_next = GNT0;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; async reset drops the grant immediately.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Priority pointer and mux select move only when a new grant bit rises.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_last <= 1'b1;
      r_sel  <= 1'b0;
    end else if (w_entry) begin
      r_last <= w_new_idx;
      r_sel  <= w_new_idx;
    end
  end

  assign bus.O_GNT  = {r_state == GNT1, r_state == GNT0};
  assign bus.O_SEL  = r_sel;
  assign bus.O_BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural owner/waiting-time model
// pushes the expected outputs each edge, a monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
    logic       preempt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // reference model state: owner -1 means nobody holds the port
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;
  int m_wait  = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: decides the owner for the next cycle from the sampled requests.
  always @(posedge clk) begin : model
    exp_t       e;
    logic [1:0] r;
    int         nxt;
    int         k;
    int         o;
    int         waited;
    bit         pre;
    r   = bus.I_REQ;
    pre = 1'b0;
    if (rst) begin
      m_owner = -1; m_last = 1; m_sel = 0; m_wait = 0;
    end else begin
      if (m_owner < 0) begin
        if (r == 2'b11)  nxt = 1 - m_last;
        else if (r[0])   nxt = 0;
        else if (r[1])   nxt = 1;
        else             nxt = -1;
        m_wait = 0;
      end else begin
        k = m_owner;
        o = 1 - k;
        waited = r[o] ? m_wait + 1 : 0;
        if (!r[k]) begin
          nxt = r[o] ? o : -1;
        end else if (TIMEOUT && waited >= MAX_HOLD) begin
          nxt = o;
          pre = 1'b1;
        end else begin
          nxt = k;
        end
        m_wait = (nxt == k) ? waited : 0;
      end
      if (nxt >= 0 && nxt != m_owner) begin
        m_last = nxt;
        m_sel  = nxt;
      end
      m_owner = nxt;
    end
    e.gnt     = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
    e.sel     = (m_sel != 0);
    e.busy    = (m_owner >= 0);
    e.preempt = pre;
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs just after each edge against the scoreboard.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",     int'(bus.O_GNT),     int'(e.gnt));
      chk("sel",     int'(bus.O_SEL),     int'(e.sel));
      chk("busy",    int'(bus.O_BUSY),    int'(e.busy));
      chk("preempt", int'(bus.O_PREEMPT), int'(e.preempt));
      chk("gnt_not_both", int'(bus.O_GNT == 2'b11), 0);
    end
  end

  task automatic drive(input logic [1:0] req, input int n);
    bus.I_REQ = req;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [1:0] r;
    bus.I_REQ = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_gnt",  int'(bus.O_GNT), 0);
    chk("reset_sel",  int'(bus.O_SEL), 0);
    chk("reset_busy", int'(bus.O_BUSY), 0);

    // single request, then release
    drive(2'b01, 3);
    drive(2'b00, 2);
    // simultaneous requests, hand-over, idle, re-tie
    drive(2'b11, 2);
    drive(2'b10, 2);
    drive(2'b00, 2);
    drive(2'b11, 2);
    drive(2'b00, 2);
    // requester 1 held, requester 0 pulsing 3-on/1-off
    for (int i = 0; i < 40; i++) drive({1'b1, (i % 4) != 3}, 1);
    drive(2'b00, 2);
    // long contention: timeout behaviour or indefinite hold
    drive(2'b11, 50);
    drive(2'b00, 2);

    // async reset during GNT1
    drive(2'b10, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt",  int'(bus.O_GNT), 0);
    chk("async_rst_busy", int'(bus.O_BUSY), 0);
    @(negedge clk);
    bus.I_REQ = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_gnt", int'(bus.O_GNT), 1);
    drive(2'b11, 3);
    drive(2'b00, 2);

    // random request traffic
    r = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(4) == 0) r[0] = ~r[0];
      if ($urandom_range(4) == 0) r[1] = ~r[1];
      drive(r, 1);
    end
    drive(2'b00, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
